// File: rtl/rob_ctrl_pkg.sv
// Shared reorder-buffer constants and the entry type encoding.
// Imported by rob_ctrl and rob_query_port.
package rob_ctrl_pkg;

  localparam int ROB_SIZE_DEF = 16;
  localparam int ROB_POS_WID  = 4;
  localparam int ROB_ID_WID   = ROB_POS_WID + 1;
  localparam int DATA_WID     = 32;
  localparam int REG_POS_WID  = 5;

  typedef enum logic [1:0] {
    ROB_TYPE_REG    = 2'd0,
    ROB_TYPE_STORE  = 2'd1,
    ROB_TYPE_BRANCH = 2'd2
  } rob_type_e;

endpackage

// File: rtl/rob_query_port.sv
// Combinational operand lookup into the reorder buffer for one decoder query.
// With ROB_CDB_FWD_EN defined, same-cycle ALU/LSB write-backs are forwarded (ALU first).
module rob_query_port #(
  parameter int  ROB_SIZE = 16,
  parameter int  DATA_W   = 32,
  localparam int ROB_POS  = $clog2(ROB_SIZE)
) (
  input  logic [ROB_POS-1:0]  qry_pos,
  input  logic [ROB_SIZE-1:0] entry_ready,
  input  logic [DATA_W-1:0]   entry_val [ROB_SIZE],
  input  logic                alu_valid,
  input  logic [ROB_POS-1:0]  alu_pos,
  input  logic [DATA_W-1:0]   alu_val,
  input  logic                lsb_valid,
  input  logic [ROB_POS-1:0]  lsb_pos,
  input  logic [DATA_W-1:0]   lsb_val,
  output logic                qry_ready,
  output logic [DATA_W-1:0]   qry_val
);

`ifdef ROB_CDB_FWD_EN
  always_comb begin
    qry_ready = entry_ready[qry_pos];
    qry_val   = entry_val[qry_pos];
    if (lsb_valid && lsb_pos == qry_pos) begin
      qry_ready = 1'b1;
      qry_val   = lsb_val;
    end
    if (alu_valid && alu_pos == qry_pos) begin
      qry_ready = 1'b1;
      qry_val   = alu_val;
    end
  end
`else
  logic unused_cdb;
  assign unused_cdb = ^{alu_valid, alu_pos, alu_val, lsb_valid, lsb_pos, lsb_val};
  assign qry_ready  = entry_ready[qry_pos];
  assign qry_val    = entry_val[qry_pos];
`endif

endmodule

// File: rtl/rob_ctrl.sv
// Reorder buffer: in-order allocation, out-of-order write-back, in-order retire with rollback.
// Optional ROB_CDB_FWD_EN forwards same-cycle write-backs onto the operand query ports.
module rob_ctrl
  import rob_ctrl_pkg::*;
#(
  parameter int  ROB_SIZE = ROB_SIZE_DEF,
  parameter int  DATA_W   = DATA_WID,
  localparam int ROB_POS  = $clog2(ROB_SIZE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  output logic                   full,
  input  logic                   issue,
  input  logic [1:0]             issue_type,
  input  logic [REG_POS_WID-1:0] issue_rd,
  input  logic                   issue_pred_jump,
  output logic [ROB_POS-1:0]     issue_pos,
  input  logic                   alu_valid,
  input  logic [ROB_POS-1:0]     alu_pos,
  input  logic [DATA_W-1:0]      alu_val,
  input  logic                   alu_jump,
  input  logic [DATA_W-1:0]      alu_pc,
  input  logic                   lsb_valid,
  input  logic [ROB_POS-1:0]     lsb_pos,
  input  logic [DATA_W-1:0]      lsb_val,
  input  logic [ROB_POS-1:0]     qry1_pos,
  input  logic [ROB_POS-1:0]     qry2_pos,
  output logic                   qry1_ready,
  output logic                   qry2_ready,
  output logic [DATA_W-1:0]      qry1_val,
  output logic [DATA_W-1:0]      qry2_val,
  output logic                   rob_commit,
  output logic [REG_POS_WID-1:0] rob_commit_rd,
  output logic [DATA_W-1:0]      rob_commit_val,
  output logic [ROB_POS-1:0]     rob_commit_rob_pos,
  output logic                   commit_store,
  output logic                   rollback,
  output logic [DATA_W-1:0]      rollback_pc
);

  localparam int CNT_W = ROB_POS + 1;

  logic [ROB_SIZE-1:0]    busy_q, busy_d, ready_q, ready_d;
  logic [ROB_SIZE-1:0]    pred_jump_q, pred_jump_d, real_jump_q, real_jump_d;
  rob_type_e              type_q [ROB_SIZE];
  rob_type_e              type_d [ROB_SIZE];
  logic [REG_POS_WID-1:0] rd_q   [ROB_SIZE];
  logic [REG_POS_WID-1:0] rd_d   [ROB_SIZE];
  logic [DATA_W-1:0]      val_q  [ROB_SIZE];
  logic [DATA_W-1:0]      val_d  [ROB_SIZE];
  logic [DATA_W-1:0]      pc_q   [ROB_SIZE];
  logic [DATA_W-1:0]      pc_d   [ROB_SIZE];
  logic [ROB_POS-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;

  logic                   commit_q, commit_d, store_q, store_d, rollback_q, rollback_d;
  logic [REG_POS_WID-1:0] commit_rd_q, commit_rd_d;
  logic [DATA_W-1:0]      commit_val_q, commit_val_d, rollback_pc_q, rollback_pc_d;
  logic [ROB_POS-1:0]     commit_pos_q, commit_pos_d;

  logic do_issue, head_ready, mispredict;

  assign full       = (count_q == CNT_W'(ROB_SIZE));
  assign issue_pos  = tail_q;
  assign do_issue   = issue && !full;
  assign head_ready = busy_q[head_q] && ready_q[head_q];
  assign mispredict = head_ready && (type_q[head_q] == ROB_TYPE_BRANCH) &&
                      (real_jump_q[head_q] != pred_jump_q[head_q]);

  always_comb begin
    busy_d        = busy_q;
    ready_d       = ready_q;
    pred_jump_d   = pred_jump_q;
    real_jump_d   = real_jump_q;
    type_d        = type_q;
    rd_d          = rd_q;
    val_d         = val_q;
    pc_d          = pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    commit_d      = 1'b0;
    store_d       = 1'b0;
    rollback_d    = 1'b0;
    commit_rd_d   = commit_rd_q;
    commit_val_d  = commit_val_q;
    commit_pos_d  = commit_pos_q;
    rollback_pc_d = rollback_pc_q;

    if (rdy) begin
      // LSB first so a colliding ALU write-back to the same slot overrides it
      if (lsb_valid) begin
        ready_d[lsb_pos] = 1'b1;
        val_d[lsb_pos]   = lsb_val;
      end
      if (alu_valid) begin
        ready_d[alu_pos]     = 1'b1;
        val_d[alu_pos]       = alu_val;
        real_jump_d[alu_pos] = alu_jump;
        pc_d[alu_pos]        = alu_pc;
      end

      if (do_issue) begin
        busy_d[tail_q]      = 1'b1;
        ready_d[tail_q]     = 1'b0;
        type_d[tail_q]      = rob_type_e'(issue_type);
        rd_d[tail_q]        = issue_rd;
        pred_jump_d[tail_q] = issue_pred_jump;
        tail_d              = tail_q + ROB_POS'(1);
      end

      if (head_ready) begin
        busy_d[head_q] = 1'b0;
        head_d         = head_q + ROB_POS'(1);
        case (type_q[head_q])
          ROB_TYPE_REG: begin
            commit_d     = 1'b1;
            commit_rd_d  = rd_q[head_q];
            commit_val_d = val_q[head_q];
            commit_pos_d = head_q;
          end
          ROB_TYPE_STORE:  store_d = 1'b1;
          ROB_TYPE_BRANCH: begin
            if (mispredict) begin
              rollback_d    = 1'b1;
              rollback_pc_d = pc_q[head_q];
            end
          end
          default: ;
        endcase
      end

      case ({do_issue, head_ready})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase

      // A mispredict squashes everything younger, including this cycle's issue and write-backs
      if (mispredict) begin
        busy_d  = '0;
        ready_d = '0;
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q        <= '0;
      ready_q       <= '0;
      pred_jump_q   <= '0;
      real_jump_q   <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        type_q[i] <= ROB_TYPE_REG;
        rd_q[i]   <= '0;
        val_q[i]  <= '0;
        pc_q[i]   <= '0;
      end
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      commit_q      <= 1'b0;
      store_q       <= 1'b0;
      rollback_q    <= 1'b0;
      commit_rd_q   <= '0;
      commit_val_q  <= '0;
      commit_pos_q  <= '0;
      rollback_pc_q <= '0;
    end else begin
      busy_q        <= busy_d;
      ready_q       <= ready_d;
      pred_jump_q   <= pred_jump_d;
      real_jump_q   <= real_jump_d;
      type_q        <= type_d;
      rd_q          <= rd_d;
      val_q         <= val_d;
      pc_q          <= pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      commit_q      <= commit_d;
      store_q       <= store_d;
      rollback_q    <= rollback_d;
      commit_rd_q   <= commit_rd_d;
      commit_val_q  <= commit_val_d;
      commit_pos_q  <= commit_pos_d;
      rollback_pc_q <= rollback_pc_d;
    end
  end

  assign rob_commit         = commit_q;
  assign rob_commit_rd      = commit_rd_q;
  assign rob_commit_val     = commit_val_q;
  assign rob_commit_rob_pos = commit_pos_q;
  assign commit_store       = store_q;
  assign rollback           = rollback_q;
  assign rollback_pc        = rollback_pc_q;

  rob_query_port #(.ROB_SIZE(ROB_SIZE), .DATA_W(DATA_W)) u_qry1 (
    .qry_pos     (qry1_pos),
    .entry_ready (ready_q),
    .entry_val   (val_q),
    .alu_valid   (alu_valid),
    .alu_pos     (alu_pos),
    .alu_val     (alu_val),
    .lsb_valid   (lsb_valid),
    .lsb_pos     (lsb_pos),
    .lsb_val     (lsb_val),
    .qry_ready   (qry1_ready),
    .qry_val     (qry1_val)
  );

  rob_query_port #(.ROB_SIZE(ROB_SIZE), .DATA_W(DATA_W)) u_qry2 (
    .qry_pos     (qry2_pos),
    .entry_ready (ready_q),
    .entry_val   (val_q),
    .alu_valid   (alu_valid),
    .alu_pos     (alu_pos),
    .alu_val     (alu_val),
    .lsb_valid   (lsb_valid),
    .lsb_pos     (lsb_pos),
    .lsb_val     (lsb_val),
    .qry_ready   (qry2_ready),
    .qry_val     (qry2_val)
  );

endmodule

// File: tb/tb_rob_ctrl.sv
// Directed bench for rob_ctrl: a vector table for the main flow plus hand-written
// sequences for the full/wrap boundary and asynchronous reset.
module tb_rob_ctrl;

  localparam logic [1:0] T_REG = 2'd0, T_STORE = 2'd1, T_BRANCH = 2'd2;

  logic        clk, rst, rdy, full, issue, issue_pred_jump;
  logic [1:0]  issue_type;
  logic [4:0]  issue_rd, rob_commit_rd;
  logic [3:0]  issue_pos, alu_pos, lsb_pos, qry1_pos, qry2_pos, rob_commit_rob_pos;
  logic        alu_valid, alu_jump, lsb_valid, qry1_ready, qry2_ready;
  logic [31:0] alu_val, alu_pc, lsb_val, qry1_val, qry2_val, rob_commit_val, rollback_pc;
  logic        rob_commit, commit_store, rollback;

  int testsRun = 0;
  int testsFailed = 0;

  rob_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .full(full),
    .issue(issue), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_pred_jump(issue_pred_jump), .issue_pos(issue_pos),
    .alu_valid(alu_valid), .alu_pos(alu_pos), .alu_val(alu_val),
    .alu_jump(alu_jump), .alu_pc(alu_pc),
    .lsb_valid(lsb_valid), .lsb_pos(lsb_pos), .lsb_val(lsb_val),
    .qry1_pos(qry1_pos), .qry2_pos(qry2_pos),
    .qry1_ready(qry1_ready), .qry2_ready(qry2_ready),
    .qry1_val(qry1_val), .qry2_val(qry2_val),
    .rob_commit(rob_commit), .rob_commit_rd(rob_commit_rd),
    .rob_commit_val(rob_commit_val), .rob_commit_rob_pos(rob_commit_rob_pos),
    .commit_store(commit_store), .rollback(rollback), .rollback_pc(rollback_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy, issue, pj, av, aj, lv;
    logic [1:0]  itype;
    logic [4:0]  ird;
    logic [3:0]  ap, lp, q1;
    logic [31:0] aval, apc, lval;
    logic        eCommit, eStore, eRb, chkQ, eQr;
    logic [4:0]  eRd;
    logic [3:0]  ePos, eIpos;
    logic [31:0] eVal, eRbPc, eQv;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t idle(input logic [3:0] ipos);
    vec_t v;
    v = '{rdy: 1'b1, default: '0};
    v.eIpos = ipos;
    return v;
  endfunction

  function automatic vec_t iss(input logic [1:0] t, input logic [4:0] rd, input logic pj,
                               input logic [3:0] ipos);
    vec_t v;
    v = idle(ipos);
    v.issue = 1'b1; v.itype = t; v.ird = rd; v.pj = pj;
    return v;
  endfunction

  function automatic vec_t alu(input logic [3:0] p, input logic [31:0] val, input logic j,
                               input logic [31:0] pc, input logic [3:0] ipos);
    vec_t v;
    v = idle(ipos);
    v.av = 1'b1; v.ap = p; v.aval = val; v.aj = j; v.apc = pc;
    return v;
  endfunction

  function automatic vec_t cm(input vec_t vin, input logic [4:0] rd, input logic [31:0] val,
                              input logic [3:0] p);
    vec_t v;
    v = vin;
    v.eCommit = 1'b1; v.eRd = rd; v.eVal = val; v.ePos = p;
    return v;
  endfunction

  function automatic vec_t qy(input vec_t vin, input logic [3:0] p, input logic r,
                              input logic [31:0] val);
    vec_t v;
    v = vin;
    v.q1 = p; v.chkQ = 1'b1; v.eQr = r; v.eQv = val;
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    rdy = 1'b1; issue = 1'b0; issue_type = T_REG; issue_rd = '0; issue_pred_jump = 1'b0;
    alu_valid = 1'b0; alu_pos = '0; alu_val = '0; alu_jump = 1'b0; alu_pc = '0;
    lsb_valid = 1'b0; lsb_pos = '0; lsb_val = '0; qry1_pos = '0; qry2_pos = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    rdy = v.rdy; issue = v.issue; issue_type = v.itype; issue_rd = v.ird;
    issue_pred_jump = v.pj;
    alu_valid = v.av; alu_pos = v.ap; alu_val = v.aval; alu_jump = v.aj; alu_pc = v.apc;
    lsb_valid = v.lv; lsb_pos = v.lp; lsb_val = v.lval; qry1_pos = v.q1;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    checkVal($sformatf("v%0d.rob_commit", idx), 32'(rob_commit), 32'(v.eCommit));
    checkVal($sformatf("v%0d.commit_store", idx), 32'(commit_store), 32'(v.eStore));
    checkVal($sformatf("v%0d.rollback", idx), 32'(rollback), 32'(v.eRb));
    checkVal($sformatf("v%0d.full", idx), 32'(full), 32'd0);
    checkVal($sformatf("v%0d.issue_pos", idx), 32'(issue_pos), 32'(v.eIpos));
    if (v.eCommit) begin
      checkVal($sformatf("v%0d.commit_rd", idx), 32'(rob_commit_rd), 32'(v.eRd));
      checkVal($sformatf("v%0d.commit_val", idx), rob_commit_val, v.eVal);
      checkVal($sformatf("v%0d.commit_pos", idx), 32'(rob_commit_rob_pos), 32'(v.ePos));
    end
    if (v.eRb)
      checkVal($sformatf("v%0d.rollback_pc", idx), rollback_pc, v.eRbPc);
    if (v.chkQ) begin
      checkVal($sformatf("v%0d.qry1_ready", idx), 32'(qry1_ready), 32'(v.eQr));
      if (v.eQr)
        checkVal($sformatf("v%0d.qry1_val", idx), qry1_val, v.eQv);
    end
  endtask

  task automatic doReset();
    clearInputs();
    rst = 1'b1;
    stepEdge();
    rst = 1'b0;
    checkVal("reset.rob_commit", 32'(rob_commit), 32'd0);
    checkVal("reset.commit_store", 32'(commit_store), 32'd0);
    checkVal("reset.rollback", 32'(rollback), 32'd0);
    checkVal("reset.full", 32'(full), 32'd0);
    checkVal("reset.issue_pos", 32'(issue_pos), 32'd0);
  endtask

  initial begin
    vec_t v;

    tbl.push_back(qy(iss(T_REG, 5'd5, 1'b0, 4'd1), 4'd0, 1'b0, 32'h0));
    tbl.push_back(qy(alu(4'd0, 32'h1234, 1'b0, 32'h0, 4'd1), 4'd0, 1'b1, 32'h1234));
    tbl.push_back(cm(idle(4'd1), 5'd5, 32'h1234, 4'd0));
    tbl.push_back(idle(4'd1));
    tbl.push_back(iss(T_REG, 5'd1, 1'b0, 4'd2));
    tbl.push_back(iss(T_REG, 5'd2, 1'b0, 4'd3));
    tbl.push_back(iss(T_REG, 5'd3, 1'b0, 4'd4));
    tbl.push_back(alu(4'd3, 32'h33, 1'b0, 32'h0, 4'd4));
    v = idle(4'd4); v.lv = 1'b1; v.lp = 4'd2; v.lval = 32'h22;
    tbl.push_back(qy(v, 4'd2, 1'b1, 32'h22));
    tbl.push_back(alu(4'd1, 32'h11, 1'b0, 32'h0, 4'd4));
    tbl.push_back(cm(idle(4'd4), 5'd1, 32'h11, 4'd1));
    tbl.push_back(cm(idle(4'd4), 5'd2, 32'h22, 4'd2));
    tbl.push_back(cm(idle(4'd4), 5'd3, 32'h33, 4'd3));
    tbl.push_back(idle(4'd4));
    // store retire
    tbl.push_back(iss(T_STORE, 5'd0, 1'b0, 4'd5));
    v = idle(4'd5); v.lv = 1'b1; v.lp = 4'd4; v.lval = 32'h1000;
    tbl.push_back(v);
    v = idle(4'd5); v.eStore = 1'b1;
    tbl.push_back(v);
    tbl.push_back(idle(4'd5));
    // correctly predicted branch retires silently
    tbl.push_back(iss(T_BRANCH, 5'd0, 1'b1, 4'd6));
    tbl.push_back(alu(4'd5, 32'h0, 1'b1, 32'h40, 4'd6));
    tbl.push_back(idle(4'd6));
    tbl.push_back(iss(T_REG, 5'd7, 1'b0, 4'd7));
    tbl.push_back(alu(4'd6, 32'h66, 1'b0, 32'h0, 4'd7));
    tbl.push_back(cm(idle(4'd7), 5'd7, 32'h66, 4'd6));
    // ALU and LSB collide on one slot: ALU value wins
    tbl.push_back(iss(T_REG, 5'd9, 1'b0, 4'd8));
    v = alu(4'd7, 32'hAA, 1'b0, 32'h0, 4'd8); v.lv = 1'b1; v.lp = 4'd7; v.lval = 32'hBB;
    tbl.push_back(qy(v, 4'd7, 1'b1, 32'hAA));
    tbl.push_back(cm(idle(4'd8), 5'd9, 32'hAA, 4'd7));
    // mispredicted branch with a younger ready REG behind it
    tbl.push_back(iss(T_BRANCH, 5'd0, 1'b0, 4'd9));
    tbl.push_back(iss(T_REG, 5'd4, 1'b0, 4'd10));
    tbl.push_back(alu(4'd9, 32'h99, 1'b0, 32'h0, 4'd10));
    tbl.push_back(alu(4'd8, 32'h0, 1'b1, 32'h80, 4'd10));
    v = idle(4'd0); v.eRb = 1'b1; v.eRbPc = 32'h80;
    tbl.push_back(v);
    tbl.push_back(idle(4'd0));
    tbl.push_back(idle(4'd0));
    // rdy low freezes state and suppresses pulses
    v = iss(T_REG, 5'd6, 1'b0, 4'd0); v.rdy = 1'b0;
    tbl.push_back(v);
    tbl.push_back(iss(T_REG, 5'd6, 1'b0, 4'd1));
    tbl.push_back(alu(4'd0, 32'h55, 1'b0, 32'h0, 4'd1));
    v = idle(4'd1); v.rdy = 1'b0;
    tbl.push_back(v);
    tbl.push_back(cm(idle(4'd1), 5'd6, 32'h55, 4'd0));
    tbl.push_back(idle(4'd1));

    doReset();
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      stepEdge();
      checkOutput(tbl[i], i);
    end

    // fill to full, reject the extra issue, then wrap
    doReset();
    for (int i = 0; i < 16; i++) begin
      issue = 1'b1; issue_type = T_REG; issue_rd = 5'(i);
      stepEdge();
      checkVal($sformatf("fill%0d.issue_pos", i), 32'(issue_pos), 32'((i + 1) % 16));
      checkVal($sformatf("fill%0d.full", i), 32'(full), (i == 15) ? 32'd1 : 32'd0);
    end
    issue_rd = 5'd30;
    stepEdge();
    checkVal("overfill.issue_pos", 32'(issue_pos), 32'd0);
    checkVal("overfill.full", 32'(full), 32'd1);
    issue = 1'b0; alu_valid = 1'b1; alu_pos = 4'd0; alu_val = 32'hF0;
    stepEdge();
    checkVal("full_wb.full", 32'(full), 32'd1);
    alu_valid = 1'b0;
    stepEdge();
    checkVal("full_commit.rob_commit", 32'(rob_commit), 32'd1);
    checkVal("full_commit.rd", 32'(rob_commit_rd), 32'd0);
    checkVal("full_commit.val", rob_commit_val, 32'hF0);
    checkVal("full_commit.full", 32'(full), 32'd0);
    issue = 1'b1; issue_rd = 5'd20;
    stepEdge();
    checkVal("wrap.issue_pos", 32'(issue_pos), 32'd1);
    checkVal("wrap.full", 32'(full), 32'd1);
    issue = 1'b0; alu_valid = 1'b1; alu_pos = 4'd1; alu_val = 32'hF1;
    stepEdge();
    alu_valid = 1'b0; issue = 1'b1; issue_rd = 5'd21;
    stepEdge();
    checkVal("issue_at_commit.rob_commit", 32'(rob_commit), 32'd1);
    checkVal("issue_at_commit.rd", 32'(rob_commit_rd), 32'd1);
    checkVal("issue_at_commit.pos", 32'(rob_commit_rob_pos), 32'd1);
    checkVal("issue_at_commit.issue_pos", 32'(issue_pos), 32'd1);
    checkVal("issue_at_commit.full", 32'(full), 32'd0);
    stepEdge();
    checkVal("refill.issue_pos", 32'(issue_pos), 32'd2);
    checkVal("refill.full", 32'(full), 32'd1);
    issue = 1'b0;

    // asynchronous reset while a commit pulse is showing
    doReset();
    for (int i = 0; i < 5; i++) begin
      issue = 1'b1; issue_type = T_REG; issue_rd = 5'(10 + i);
      stepEdge();
    end
    issue = 1'b0; alu_valid = 1'b1; alu_pos = 4'd0; alu_val = 32'h77;
    stepEdge();
    alu_valid = 1'b0;
    stepEdge();
    checkVal("pre_rst.rob_commit", 32'(rob_commit), 32'd1);
    checkVal("pre_rst.issue_pos", 32'(issue_pos), 32'd5);
    #2 rst = 1'b1;
    #1;
    checkVal("async_rst.rob_commit", 32'(rob_commit), 32'd0);
    checkVal("async_rst.commit_rd", 32'(rob_commit_rd), 32'd0);
    checkVal("async_rst.commit_val", rob_commit_val, 32'd0);
    checkVal("async_rst.issue_pos", 32'(issue_pos), 32'd0);
    checkVal("async_rst.full", 32'(full), 32'd0);
    checkVal("async_rst.rollback", 32'(rollback), 32'd0);
    #2 rst = 1'b0;
    stepEdge();
    checkVal("post_rst.issue_pos", 32'(issue_pos), 32'd0);
    checkVal("post_rst.rob_commit", 32'(rob_commit), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
